// File: rtl/cbx_pkg.sv
`default_nettype none
// ============================================================================
// cbx_pkg: shared helpers and default sizing for the cbx_param connection block
// Revision: 1.0
// ============================================================================
package cbx_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int tap(input int i, input int k, input int stride, input int chan_w);
        return (i + k * stride) % chan_w;
    endfunction

    localparam int CHAN_W_DEF   = 20;
    localparam int NUM_IPIN_DEF = 9;
    localparam int MUX_SIZE_DEF = 10;
    localparam int STRIDE_DEF   = 2;
    localparam int SEL_W        = clog2(MUX_SIZE_DEF);
    localparam int CFG_BITS     = NUM_IPIN_DEF * SEL_W;

endpackage
`default_nettype wire

// File: rtl/cbx_cfg_chain.sv
`default_nettype none
// ============================================================================
// cbx_cfg_chain: shadow shift chain, bit counter and atomic commit into the
// active configuration register. Optional readback under CBX_READBACK_EN.
// Revision: 1.0
// ============================================================================
module cbx_cfg_chain
    import cbx_pkg::*;
#(
    parameter int CFG_LEN = CFG_BITS
) (
    input  logic               prog_clk,
    input  logic               pReset_n,
    input  logic               config_enable_i,
    input  logic               ccff_head_i,
    input  logic               commit_i,
`ifdef CBX_READBACK_EN
    input  logic               readback_i,
`endif
    output logic [CFG_LEN-1:0] active_o,
    output logic               cfg_valid_o,
    output logic               cfg_count_err_o,
    output logic               ccff_tail_o
);

    localparam int                CNT_W    = clog2(CFG_LEN + 2);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CFG_LEN);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(CFG_LEN + 1);

    logic [CFG_LEN-1:0] chain_q, chain_d;
    logic [CFG_LEN-1:0] active_q, active_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tail_q, tail_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;

    // Shifting has priority; commit and readback are only seen while idle.
    always_comb begin
        chain_d  = chain_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        tail_d   = tail_q;
        valid_d  = valid_q;
        err_d    = err_q;
        if (config_enable_i) begin
            chain_d = {chain_q[CFG_LEN-2:0], ccff_head_i};
            tail_d  = chain_q[CFG_LEN-1];
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
        end else if (commit_i) begin
            cnt_d = '0;
            if (cnt_q == CNT_FULL) begin
                active_d = chain_q;
                valid_d  = 1'b1;
                err_d    = 1'b0;
            end else begin
                err_d    = 1'b1;
            end
        end
`ifdef CBX_READBACK_EN
        else if (readback_i) begin
            chain_d = active_q;
            cnt_d   = '0;
        end
`endif
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            chain_q  <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            tail_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            chain_q  <= chain_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            tail_q   <= tail_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign active_o        = active_q;
    assign cfg_valid_o     = valid_q;
    assign cfg_count_err_o = err_q;
    assign ccff_tail_o     = tail_q;

endmodule
`default_nettype wire

// File: rtl/cbx_param.sv
`default_nettype none
// ============================================================================
// cbx_param: parametrised X-channel connection block with track feedthroughs
// and NUM_IPIN routing muxes. Optional macro: CBX_READBACK_EN (readback port).
// Revision: 1.0
// ============================================================================
module cbx_param
    import cbx_pkg::*;
#(
    parameter int CHAN_W   = CHAN_W_DEF,
    parameter int NUM_IPIN = NUM_IPIN_DEF,
    parameter int MUX_SIZE = MUX_SIZE_DEF,
    parameter int STRIDE   = STRIDE_DEF
) (
    input  logic                prog_clk,
    input  logic                pReset_n,
    input  logic                config_enable,
    input  logic                ccff_head,
    input  logic                commit,
`ifdef CBX_READBACK_EN
    input  logic                readback,
`endif
    input  logic [CHAN_W-1:0]   chanx_left_in,
    input  logic [CHAN_W-1:0]   chanx_right_in,
    output logic [CHAN_W-1:0]   chanx_left_out,
    output logic [CHAN_W-1:0]   chanx_right_out,
    output logic [NUM_IPIN-1:0] ipin_out,
    output logic                ccff_tail,
    output logic                cfg_valid,
    output logic                cfg_count_err,
    output logic                sel_range_err
);

    localparam int                 SEL_WIDTH = clog2(MUX_SIZE);
    localparam int                 CHAIN_LEN = NUM_IPIN * SEL_WIDTH;
    localparam int                 MUX_PAD   = 1 << SEL_WIDTH;
    localparam logic [SEL_WIDTH:0] SEL_LIMIT = (SEL_WIDTH + 1)'(MUX_SIZE);

    logic [CHAIN_LEN-1:0] active;
    logic [NUM_IPIN-1:0]  range_hit;

    assign chanx_left_out  = chanx_right_in;
    assign chanx_right_out = chanx_left_in;

    cbx_cfg_chain #(
        .CFG_LEN (CHAIN_LEN)
    ) u_cfg_chain (
        .prog_clk        (prog_clk),
        .pReset_n        (pReset_n),
        .config_enable_i (config_enable),
        .ccff_head_i     (ccff_head),
        .commit_i        (commit),
`ifdef CBX_READBACK_EN
        .readback_i      (readback),
`endif
        .active_o        (active),
        .cfg_valid_o     (cfg_valid),
        .cfg_count_err_o (cfg_count_err),
        .ccff_tail_o     (ccff_tail)
    );

    generate
        for (genvar i = 0; i < NUM_IPIN; i++) begin : g_ipin
            logic [SEL_WIDTH-1:0] sel;
            logic [MUX_PAD-1:0]   mux_in;

            assign sel = active[i*SEL_WIDTH +: SEL_WIDTH];

            // Even mux inputs take the left track, odd ones the right track.
            for (genvar k = 0; k < MUX_SIZE / 2; k++) begin : g_tap
                localparam int T = tap(i, k, STRIDE, CHAN_W);
                assign mux_in[2*k]   = chanx_left_in[T];
                assign mux_in[2*k+1] = chanx_right_in[T];
            end
            if (MUX_PAD > MUX_SIZE) begin : g_pad
                assign mux_in[MUX_PAD-1:MUX_SIZE] = '0;
            end

            assign range_hit[i] = ({1'b0, sel} >= SEL_LIMIT);
            assign ipin_out[i]  = cfg_valid & ~range_hit[i] & mux_in[sel];
        end
    endgenerate

    assign sel_range_err = cfg_valid & (|range_hit);

endmodule
`default_nettype wire

// File: tb/tb_cbx_param.sv
`default_nettype none
// ============================================================================
// tb_cbx_param: self-checking bench for cbx_param (default sizing).
// Revision: 1.0
// ============================================================================
module tb_cbx_param;
    import cbx_pkg::*;

    localparam int CW = 20;
    localparam int NI = 9;
    localparam int MS = 10;
    localparam int SW = 4;
    localparam int CB = 36;

    logic          prog_clk = 1'b0;
    logic          pReset_n;
    logic          config_enable;
    logic          ccff_head;
    logic          commit;
`ifdef CBX_READBACK_EN
    logic          readback;
`endif
    logic [CW-1:0] chanx_left_in, chanx_right_in, chanx_left_out, chanx_right_out;
    logic [NI-1:0] ipin_out;
    logic          ccff_tail, cfg_valid, cfg_count_err, sel_range_err;

    cbx_param dut (
        .prog_clk        (prog_clk),
        .pReset_n        (pReset_n),
        .config_enable   (config_enable),
        .ccff_head       (ccff_head),
        .commit          (commit),
`ifdef CBX_READBACK_EN
        .readback        (readback),
`endif
        .chanx_left_in   (chanx_left_in),
        .chanx_right_in  (chanx_right_in),
        .chanx_left_out  (chanx_left_out),
        .chanx_right_out (chanx_right_out),
        .ipin_out        (ipin_out),
        .ccff_tail       (ccff_tail),
        .cfg_valid       (cfg_valid),
        .cfg_count_err   (cfg_count_err),
        .sel_range_err   (sel_range_err)
    );

    always #5 prog_clk = ~prog_clk;

    int n_vec = 0;
    int n_err = 0;
    bit rnd_ch = 1'b0;

    // Reference model: chain as a bit queue (oldest bit = chain MSB), selects as integers.
    bit mq[$];
    int mcnt;
    bit mvalid, merr, mtail;
    int msel[NI];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mdl_reset();
        mq.delete();
        for (int j = 0; j < CB; j++) mq.push_back(1'b0);
        mcnt = 0; mvalid = 0; merr = 0; mtail = 0;
        for (int i = 0; i < NI; i++) msel[i] = 0;
    endtask

    function automatic int chain_sel(input int i);
        int s = 0;
        for (int b = 0; b < SW; b++) s |= int'(mq[CB-1-(i*SW+b)]) << b;
        return s;
    endfunction

    task automatic mdl_edge(input bit ce, input bit h, input bit cm, input bit rb);
        if (ce) begin
            mtail = mq.pop_front();
            mq.push_back(h);
            if (mcnt < CB + 1) mcnt++;
        end else if (cm) begin
            if (mcnt == CB) begin
                for (int i = 0; i < NI; i++) msel[i] = chain_sel(i);
                mvalid = 1; merr = 0;
            end else begin
                merr = 1;
            end
            mcnt = 0;
        end
`ifdef CBX_READBACK_EN
        else if (rb) begin
            mq.delete();
            for (int j = CB - 1; j >= 0; j--) mq.push_back(bit'((msel[j/SW] >> (j%SW)) & 1));
            mcnt = 0;
        end
`endif
    endtask

    function automatic logic [NI-1:0] exp_ipin(input logic [CW-1:0] l, input logic [CW-1:0] r);
        logic [NI-1:0] v = '0;
        for (int i = 0; i < NI; i++) begin
            int s = msel[i];
            int t = (i + (s / 2) * 2) % CW;
            if (mvalid && s < MS) v[i] = (s % 2 == 1) ? r[t] : l[t];
        end
        return v;
    endfunction

    function automatic logic exp_rerr();
        logic e = 1'b0;
        for (int i = 0; i < NI; i++) if (msel[i] >= MS) e = 1'b1;
        return e & mvalid;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".ipin"},      32'(ipin_out),        32'(exp_ipin(chanx_left_in, chanx_right_in)));
        chk({tag, ".valid"},     32'(cfg_valid),       32'(mvalid));
        chk({tag, ".cnt_err"},   32'(cfg_count_err),   32'(merr));
        chk({tag, ".range_err"}, 32'(sel_range_err),   32'(exp_rerr()));
        chk({tag, ".tail"},      32'(ccff_tail),       32'(mtail));
        chk({tag, ".left_out"},  32'(chanx_left_out),  32'(chanx_right_in));
        chk({tag, ".right_out"}, 32'(chanx_right_out), 32'(chanx_left_in));
    endtask

    task automatic step(input bit ce, input bit h, input bit cm, input bit rb);
        config_enable = ce; ccff_head = h; commit = cm;
`ifdef CBX_READBACK_EN
        readback = rb;
`endif
        if (rnd_ch) begin
            chanx_left_in  = CW'($urandom);
            chanx_right_in = CW'($urandom);
        end
        @(posedge prog_clk);
        mdl_edge(ce, h, cm, rb);
        #1;
        check_all("step");
        config_enable = 0; commit = 0;
`ifdef CBX_READBACK_EN
        readback = 0;
`endif
    endtask

    function automatic logic [CB-1:0] pack(input int sels[NI]);
        logic [CB-1:0] v = '0;
        for (int i = 0; i < NI; i++) v[i*SW +: SW] = SW'(sels[i]);
        return v;
    endfunction

    task automatic load(input int sels[NI], input int nbits, input bit collide);
        logic [CB-1:0] v = pack(sels);
        for (int n = 0; n < nbits; n++)
            step(1'b1, (n < CB) ? v[CB-1-n] : 1'b0, collide && ($urandom_range(0, 7) == 0), 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    typedef struct {
        logic [CW-1:0] l;
        logic [CW-1:0] r;
        logic [NI-1:0] ipin;
    } vec_t;

    vec_t tbl[3];
    int   s[NI];
    bit   pat[72];

    initial begin
        tbl[0] = '{l: 20'hA5A5A, r: 20'h0F0F0, ipin: 9'h05A};
        tbl[1] = '{l: 20'h00000, r: 20'h00004, ipin: 9'h001};
        tbl[2] = '{l: 20'hFFFFF, r: 20'h00000, ipin: 9'h1FE};

        pReset_n = 0; config_enable = 0; ccff_head = 0; commit = 0;
`ifdef CBX_READBACK_EN
        readback = 0;
`endif
        chanx_left_in = 20'hA5A5A; chanx_right_in = 20'h0F0F0;
        mdl_reset();
        #22 pReset_n = 1;
        #1;
        // Reset state and feedthrough
        chk("rst.ipin", 32'(ipin_out), 32'h0);
        chk("rst.valid", 32'(cfg_valid), 32'h0);
        chk("rst.tail", 32'(ccff_tail), 32'h0);
        chk("rst.range_err", 32'(sel_range_err), 32'h0);
        chk("rst.right_out", 32'(chanx_right_out), 32'hA5A5A);
        chk("rst.left_out", 32'(chanx_left_out), 32'h0F0F0);

        // Good load: ipin0 sel=3 -> right[2], others sel=0 -> left[i]
        foreach (s[i]) s[i] = 0;
        s[0] = 3;
        load(s, CB, 1'b0);
        chk("good.valid", 32'(cfg_valid), 32'h1);
        chk("good.cnt_err", 32'(cfg_count_err), 32'h0);
        for (int v = 0; v < 3; v++) begin
            chanx_left_in = tbl[v].l; chanx_right_in = tbl[v].r;
            #1;
            chk("tbl.ipin", 32'(ipin_out), 32'(tbl[v].ipin));
            chk("tbl.model", 32'(ipin_out), 32'(exp_ipin(chanx_left_in, chanx_right_in)));
        end

        // Short load: error, active unchanged; then good reload clears it
        s[0] = 5;
        load(s, CB - 1, 1'b0);
        chk("short.cnt_err", 32'(cfg_count_err), 32'h1);
        chanx_left_in = 20'h0; chanx_right_in = 20'h00004;
        #1 chk("short.ipin0", 32'(ipin_out[0]), 32'h1);
        s[0] = 3;
        load(s, CB, 1'b0);
        chk("reload.cnt_err", 32'(cfg_count_err), 32'h0);

        // Out-of-range select on ipin 4
        foreach (s[i]) s[i] = 0;
        s[4] = 12;
        load(s, CB, 1'b0);
        chanx_left_in = 20'hFFFFF; chanx_right_in = 20'hFFFFF;
        #1;
        chk("oor.range_err", 32'(sel_range_err), 32'h1);
        chk("oor.ipin4", 32'(ipin_out[4]), 32'h0);
        s[4] = 9;
        load(s, CB, 1'b0);
        chanx_left_in = 20'h0; chanx_right_in = 20'h01000;
        #1;
        chk("sel9.ipin4_hi", 32'(ipin_out[4]), 32'h1);
        chk("sel9.range_err", 32'(sel_range_err), 32'h0);
        chanx_right_in = 20'h0;
        #1 chk("sel9.ipin4_lo", 32'(ipin_out[4]), 32'h0);

        // Chain passthrough: tail repeats input 36 shifts + 1 stage later
        foreach (pat[n]) pat[n] = bit'($urandom_range(0, 1));
        for (int n = 0; n < 72; n++) begin
            step(1'b1, pat[n], 1'b0, 1'b0);
            if (n >= CB) chk("pass.tail", 32'(ccff_tail), 32'(pat[n-CB]));
        end
        // Commit during shift is ignored
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("collide.cnt_err", 32'(cfg_count_err), 32'h0);
        chk("collide.valid", 32'(cfg_valid), 32'h1);

`ifdef CBX_READBACK_EN
        begin
            logic [CB-1:0] v;
            foreach (s[i]) s[i] = 0;
            s[0] = 3; s[8] = 11; s[5] = 6;
            load(s, CB, 1'b0);
            v = pack(s);
            step(1'b0, 1'b0, 1'b0, 1'b1);
            for (int n = 0; n < CB; n++) begin
                if (n == 20) break;
                step(1'b1, 1'b0, 1'b0, 1'b0);
                chk("rb.tail", 32'(ccff_tail), 32'(v[CB-1-n]));
            end
            #2 pReset_n = 0;
            mdl_reset();
            #1;
            chk("rb.rst_tail", 32'(ccff_tail), 32'h0);
            chk("rb.rst_valid", 32'(cfg_valid), 32'h0);
            #3 pReset_n = 1;
            // Commit and readback together: commit wins
            load(s, CB, 1'b0);
            step(1'b0, 1'b0, 1'b1, 1'b1);
        end
`endif

        // Randomized loads against the model
        rnd_ch = 1'b1;
        for (int t = 0; t < 40; t++) begin
            int nb;
            foreach (s[i]) s[i] = $urandom_range(0, 15);
            case ($urandom_range(0, 4))
                0:       nb = CB - 1;
                1:       nb = CB + 1;
                default: nb = CB;
            endcase
            load(s, nb, 1'b1);
`ifdef CBX_READBACK_EN
            if ($urandom_range(0, 2) == 0) step(1'b0, 1'b0, $urandom_range(0, 1) == 1, 1'b1);
`endif
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
